// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Purpose  : Registered writeback mux with sub-word load extraction and a
//            late-load stall FSM with saturating stall counter.
// Revision : 1.0
// ============================================================================
module writeback_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_rd_dest_select,
    input  logic [4:0]       i_rd_addr,
    input  logic             i_rd_we,
    input  logic [2:0]       i_load_funct3,
    input  logic [2:0]       i_addr_lsb,
    input  logic [XLEN-1:0]  i_alu_result,
    input  logic [XLEN-1:0]  i_pc_plus_4,
    input  logic [XLEN-1:0]  i_immediate,
    input  logic             i_dmem_rvalid,
    input  logic [XLEN-1:0]  i_dmem_rdata,
    output logic             o_rf_we,
    output logic [4:0]       o_rf_waddr,
    output logic [XLEN-1:0]  o_rf_wdata,
    output logic             o_misaligned,
    output logic [CNT_W-1:0] o_stall_count
);

    typedef enum logic [0:0] {
        S_IDLE      = 1'b0,
        S_WAIT_LOAD = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [4:0]        r_rd_addr;
    logic              r_rd_we;
    logic [2:0]        r_funct3;
    logic [2:0]        r_addr_lsb;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_idle;
    logic              w_accept;
    logic              w_is_load;
    logic              w_alu_done;
    logic              w_load_done;
    logic [4:0]        w_addr;
    logic              w_we;
    logic [2:0]        w_funct3;
    logic [2:0]        w_lsb;
    logic [2:0]        w_off;
    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_load_data;
    logic [XLEN-1:0]   w_sel_data;
    logic              w_misal;
    logic              w_reserved;

    assign w_idle      = (r_state == S_IDLE);
    assign o_ready     = w_idle;
    assign w_accept    = i_valid && w_idle;
    assign w_is_load   = (i_rd_dest_select == 2'b11);
    assign w_alu_done  = w_accept && !w_is_load;
    assign w_load_done = (w_accept && w_is_load && i_dmem_rvalid) ||
                         (!w_idle && i_dmem_rvalid);

    // A load completing straight from IDLE uses live inputs, otherwise the captured copy
    assign w_addr   = w_idle ? i_rd_addr     : r_rd_addr;
    assign w_we     = w_idle ? i_rd_we       : r_rd_we;
    assign w_funct3 = w_idle ? i_load_funct3 : r_funct3;
    assign w_lsb    = w_idle ? i_addr_lsb    : r_addr_lsb;

    assign o_stall_count = r_stall_cnt;

    always_comb begin
        w_sel_data = i_alu_result;
        case (i_rd_dest_select)
            2'b01:   w_sel_data = i_immediate;
            2'b10:   w_sel_data = i_pc_plus_4;
            default: w_sel_data = i_alu_result;
        endcase
    end

    always_comb begin
        w_off       = (XLEN == 64) ? w_lsb : {1'b0, w_lsb[1:0]};
        w_shifted   = i_dmem_rdata >> {w_off, 3'b000};
        w_load_data = XLEN'($signed(w_shifted[31:0]));
        w_misal     = 1'b0;
        w_reserved  = 1'b0;
        case (w_funct3)
            3'b000: w_load_data = XLEN'($signed(w_shifted[7:0]));
            3'b100: w_load_data = XLEN'(w_shifted[7:0]);
            3'b001: begin
                w_load_data = XLEN'($signed(w_shifted[15:0]));
                w_misal     = w_off[0];
            end
            3'b101: begin
                w_load_data = XLEN'(w_shifted[15:0]);
                w_misal     = w_off[0];
            end
            3'b010: begin
                w_load_data = XLEN'($signed(w_shifted[31:0]));
                w_misal     = |w_off[1:0];
            end
            3'b110: begin
                if (XLEN == 64) begin
                    w_load_data = XLEN'(w_shifted[31:0]);
                    w_misal     = |w_off[1:0];
                end else begin
                    w_reserved  = 1'b1;
                end
            end
            3'b011: begin
                if (XLEN == 64) begin
                    w_load_data = w_shifted;
                    w_misal     = |w_off;
                end else begin
                    w_reserved  = 1'b1;
                end
            end
            default: w_reserved = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_load && !i_dmem_rvalid) begin
                    w_state_nxt = S_WAIT_LOAD;
                end
            end
            S_WAIT_LOAD: begin
                if (i_dmem_rvalid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_rd_addr   <= '0;
            r_rd_we     <= 1'b0;
            r_funct3    <= '0;
            r_addr_lsb  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && w_is_load && !i_dmem_rvalid) begin
                r_rd_addr  <= i_rd_addr;
                r_rd_we    <= i_rd_we;
                r_funct3   <= i_load_funct3;
                r_addr_lsb <= i_addr_lsb;
            end
            if (!w_idle && !i_dmem_rvalid && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    // Write data still tracks x0 targets; only rd_we=0, misaligned and reserved hold it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rf_we      <= 1'b0;
            o_rf_waddr   <= '0;
            o_rf_wdata   <= '0;
            o_misaligned <= 1'b0;
        end else begin
            o_rf_we      <= 1'b0;
            o_misaligned <= 1'b0;
            if (w_alu_done) begin
                o_rf_we <= i_rd_we && (i_rd_addr != 5'd0);
                if (i_rd_we) begin
                    o_rf_waddr <= i_rd_addr;
                    o_rf_wdata <= w_sel_data;
                end
            end else if (w_load_done) begin
                if (w_misal) begin
                    o_misaligned <= 1'b1;
                end else if (!w_reserved) begin
                    o_rf_we <= w_we && (w_addr != 5'd0);
                    if (w_we) begin
                        o_rf_waddr <= w_addr;
                        o_rf_wdata <= w_load_data;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
